veda_memory: RTL and testbench



---
 rtl/veda_memory.sv | 51 +++++
 tb/tb_veda_memory.sv | 106 ++++++++++
 2 files changed

// File: rtl/veda_memory.sv
// veda_memory: two independent 32x32 single-port banks with bank select on `mode`.
// Both the read and write-through data reach data_out one clock edge after the
// access is presented. reset clears every word and data_out.
module veda_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_BANKS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  mode
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // The declaration initialisers give zeroed contents at time zero, so the
  // block is usable without ever asserting reset.
  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] data_q = '0;

  // Storage update: reset clears both banks; a write touches only mem[mode][address].
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        for (int unsigned w = 0; w < DEPTH; w++) begin
          mem[b][w] <= '0;
        end
      end
    end else if (write_enable) begin
      mem[mode][address] <= data_in;
    end
  end

  // Output register: write-through on writes, the stored word on reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (write_enable) begin
      data_q <= data_in;
    end else begin
      data_q <= mem[mode][address];
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_veda_memory.sv
// Randomised self-checking bench for veda_memory against an array-based model.
module tb_veda_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_enable = 1'b0;
  logic [4:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        mode = 1'b0;

  // Reference state: what every location and data_out should hold.
  logic [31:0] ref_mem [2][32];
  logic [31:0] ref_out;

  int n_vec = 0;
  int n_bad = 0;

  veda_memory dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: data_out=0x%08h expected=0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  // Present one access at the falling edge, update the model for the rising
  // edge, check just after it, then scramble inputs and confirm data_out holds.
  task automatic access(input string tag, input logic rst, input logic we,
                        input logic m, input int a, input logic [31:0] d);
    @(negedge clk);
    reset = rst; write_enable = we; mode = m; address = 5'(a); data_in = d;
    @(posedge clk);
    if (rst) begin
      foreach (ref_mem[b, w]) ref_mem[b][w] = 32'h0;
      ref_out = 32'h0;
    end else if (we) begin
      ref_mem[m][a] = d;
      ref_out = d;
    end else begin
      ref_out = ref_mem[m][a];
    end
    #1;
    check(tag, data_out, ref_out);
    reset = 1'b0; write_enable = 1'($urandom); mode = 1'($urandom);
    address = 5'($urandom); data_in = $urandom;
    #2;
    check({tag, "_hold"}, data_out, ref_out);
  endtask

  initial begin
    foreach (ref_mem[b, w]) ref_mem[b][w] = 32'h0;
    ref_out = 32'h0;

    #1;
    check("powerup_out", data_out, 32'h0);

    // Directed plan
    access("rd_before_wr", 0, 0, 0, 5, 32'h0);
    access("wr_a5", 0, 1, 0, 5, 32'h1234_5678);
    access("wr_b7", 0, 1, 1, 7, 32'h1223_8897);
    access("rd_b7", 0, 0, 1, 7, 32'h0);
    access("rd_a5", 0, 0, 0, 5, 32'h0);
    access("iso_b5", 0, 0, 1, 5, 32'h0);
    access("iso_a7", 0, 0, 0, 7, 32'h0);
    access("wr_b5", 0, 1, 1, 5, 32'hDEAD_BEEF);
    access("iso_a5", 0, 0, 0, 5, 32'h0);
    access("rd_b5", 0, 0, 1, 5, 32'h0);
    access("rst_with_wr", 1, 1, 0, 3, 32'hFFFF_FFFF);
    access("post_rst_a3", 0, 0, 0, 3, 32'h0);
    access("post_rst_a5", 0, 0, 0, 5, 32'h0);
    access("post_rst_b7", 0, 0, 1, 7, 32'h0);

    // Address sweep over both banks, bank B inverted
    for (int a = 0; a < 32; a++) begin
      access("sweep_wr_a", 0, 1, 0, a, 32'(a) * 32'h0101_0101);
      access("sweep_wr_b", 0, 1, 1, a, ~(32'(a) * 32'h0101_0101));
    end
    for (int a = 0; a < 32; a++) begin
      access("sweep_rd_a", 0, 0, 0, a, 32'h0);
      access("sweep_rd_b", 0, 0, 1, a, 32'h0);
    end

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      access("rand", ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 31)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
